// File: rtl/jtpopeye_objscan.sv
// Object line scanner: walks object RAM once per line into a ping-pong
// 64-slot table, then emits one 18-bit DJ word per 4-pixel slot on the next line.
module jtpopeye_objscan #(
  parameter int NOBJ   = 64,
  parameter int MAXOBJ = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        pxl_cen,
  input  logic [7:0]  H,
  input  logic        HB,
  input  logic [7:0]  V,
  input  logic        VB,
  output logic [7:0]  ram_addr,
  input  logic [7:0]  ram_data,
  output logic [17:0] DJ,
  output logic        scan_busy,
  output logic        overflow
);

  localparam logic [17:0] EMPTY    = 18'h1C000;
  localparam logic [5:0]  LAST_IDX = 6'(NOBJ - 1);
  localparam int          CW       = $clog2(MAXOBJ + 1);
  localparam logic [CW-1:0] MAX_CNT = CW'(MAXOBJ);

  typedef enum logic [1:0] {CLEAR, IDLE, READ, EVAL} state_t;

  state_t        state;
  logic [6:0]    clr_addr;
  logic [5:0]    idx;
  logic [1:0]    byte_sel;
  logic [7:0]    obj_x, obj_y, obj_code, target;
  logic [CW-1:0] hit_cnt;
  logic          bank;     // table currently being emitted; the other one is scanned
  logic          hb_q;
  logic [17:0]   tbl [0:127];

  logic          hb_rise, hb_fall;
  logic [7:0]    row_full;
  logic [3:0]    row;
  logic          hit, slot_empty, scan_wr, emit_rd;
  logic [6:0]    back_addr, front_addr;
  logic [17:0]   new_dj;

  // NOTE: every always_comb output gets a value on every path, so no latches are inferred.
  always_comb begin
    hb_rise    = HB & ~hb_q;
    hb_fall    = ~HB & hb_q;
    row_full   = target - obj_y;
    row        = ram_data[7] ? 4'd15 - row_full[3:0] : row_full[3:0];
    hit        = (row_full < 8'd16) && (ram_data[2:0] != 3'b111);
    back_addr  = {~bank, obj_x[7:2]};
    front_addr = {bank, H[7:2]};
    slot_empty = tbl[back_addr][16:14] == 3'b111;
    new_dj     = {obj_code[7], ram_data[2:0], obj_x[1:0], ram_data[6], obj_code[6:0], row};
    // a swap landing on an EVAL cycle wins: the entry is dropped with the aborted scan
    scan_wr    = (state == EVAL) && hit && (hit_cnt < MAX_CNT) && slot_empty && !hb_rise;
    emit_rd    = pxl_cen && !HB && !VB && (H[1:0] == 2'b10) && (state != CLEAR);
  end

  // NOTE: the slot tables have no reset; the CLEAR state wipes both after every reset.
  always_ff @(posedge clk) begin
    if (state == CLEAR) tbl[clr_addr] <= EMPTY;
    if (scan_wr)        tbl[back_addr] <= new_dj;
    if (emit_rd)        tbl[front_addr] <= EMPTY;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= CLEAR;
      clr_addr  <= '0;
      idx       <= '0;
      byte_sel  <= '0;
      obj_x     <= '0;
      obj_y     <= '0;
      obj_code  <= '0;
      target    <= '0;
      hit_cnt   <= '0;
      bank      <= 1'b0;
      hb_q      <= 1'b1;
      ram_addr  <= '0;
      scan_busy <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      hb_q <= HB;
      case (state)
        CLEAR: begin
          clr_addr <= clr_addr + 7'd1;
          if (clr_addr == 7'd127) state <= IDLE;
        end
        IDLE: begin
          if (hb_fall && !VB) begin
            idx       <= '0;
            byte_sel  <= '0;
            hit_cnt   <= '0;
            overflow  <= 1'b0;
            target    <= V + 8'd1;
            ram_addr  <= '0;
            scan_busy <= 1'b1;
            state     <= READ;
          end
        end
        READ: begin
          // address runs one byte ahead of the data being captured
          byte_sel <= byte_sel + 2'd1;
          ram_addr <= {idx, byte_sel + 2'd1};
          case (byte_sel)
            2'd1: obj_x <= ram_data;
            2'd2: obj_y <= ram_data;
            2'd3: begin
              obj_code <= ram_data;
              state    <= EVAL;
            end
            default: ;
          endcase
        end
        EVAL: begin
          if (scan_wr) hit_cnt <= hit_cnt + 1'b1;
          if (hit && hit_cnt == MAX_CNT) overflow <= 1'b1;
          if (idx == LAST_IDX) begin
            scan_busy <= 1'b0;
            ram_addr  <= '0;
            state     <= IDLE;
          end else begin
            idx      <= idx + 6'd1;
            ram_addr <= {idx + 6'd1, 2'b00};
            state    <= READ;
          end
        end
        default: state <= CLEAR;
      endcase
      if (hb_rise && state != CLEAR) begin
        if (scan_busy) begin
          scan_busy <= 1'b0;
          overflow  <= 1'b1;
          state     <= IDLE;
        end
        // tables hold still through VB so the last visible scan survives to line 0
        if (!VB) bank <= ~bank;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      DJ <= EMPTY;
    end else if (pxl_cen) begin
      if (HB || VB || state == CLEAR) DJ <= EMPTY;
      else if (H[1:0] == 2'b10)       DJ <= tbl[front_addr];
    end
  end

endmodule

// File: tb/tb_jtpopeye_objscan.sv
// Directed bench for jtpopeye_objscan: builds lines of 64 blank + up to 256
// active pixels (pxl_cen every other clk) and checks every emitted slot.
module tb_jtpopeye_objscan;

  localparam logic [17:0] EMPTY = 18'h1C000;

  logic        clk = 1'b0, rst_n = 1'b0, pxl_cen = 1'b0, HB = 1'b1, VB = 1'b0;
  logic [7:0]  H = 8'h00, V = 8'h00;
  logic [7:0]  ram_addr, ram_data;
  logic [17:0] DJ;
  logic        scan_busy, overflow;

  logic [7:0]  mem [0:255];
  logic [17:0] exp_tbl [0:63];
  int          n_tests = 0, n_fail = 0;
  logic        ovf_blank, ovf_act, busy_act;

  jtpopeye_objscan #(.NOBJ(64), .MAXOBJ(16)) dut (
    .clk(clk), .rst_n(rst_n), .pxl_cen(pxl_cen), .H(H), .HB(HB), .V(V), .VB(VB),
    .ram_addr(ram_addr), .ram_data(ram_data), .DJ(DJ),
    .scan_busy(scan_busy), .overflow(overflow)
  );

  always #5 clk = ~clk;

  always_ff @(posedge clk) ram_data <= mem[ram_addr];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic clear_ram;
    for (int i = 0; i < 256; i++) mem[i] = 8'hFF;
  endtask

  task automatic clear_exp;
    for (int i = 0; i < 64; i++) exp_tbl[i] = EMPTY;
  endtask

  task automatic set_obj(input int idx, input logic [7:0] x, input logic [7:0] y,
                         input logic [7:0] code, input logic [7:0] attr);
    mem[idx*4]   = x;
    mem[idx*4+1] = y;
    mem[idx*4+2] = code;
    mem[idx*4+3] = attr;
  endtask

  // V and VB change together with the rising edge of HB at the start of the line
  task automatic run_line(input logic [7:0] v, input logic vb, input int act_len, input string tag);
    for (int p = 0; p < 64; p++) begin
      @(negedge clk);
      pxl_cen = 1'b1; HB = 1'b1; H = 8'h00;
      if (p == 0) begin V = v; VB = vb; end
      if (p == 63) begin
        ovf_blank = overflow;
        check({tag, " blank"}, DJ, EMPTY);
      end
      @(negedge clk);
      pxl_cen = 1'b0;
    end
    for (int h = 0; h < act_len; h++) begin
      @(negedge clk);
      pxl_cen = 1'b1; HB = 1'b0; H = 8'(h);
      if (h[1:0] == 2'b11)
        check($sformatf("%s slot %0d", tag, h >> 2), DJ, vb ? EMPTY : exp_tbl[h >> 2]);
      @(negedge clk);
      pxl_cen = 1'b0;
    end
    busy_act = scan_busy;
    ovf_act  = overflow;
  endtask

  initial begin
    clear_ram();
    clear_exp();

    // power-on reset
    repeat (3) @(negedge clk);
    check("reset DJ", DJ, EMPTY);
    check("reset ram_addr", ram_addr, 8'h00);
    check("reset scan_busy", scan_busy, 1'b0);
    check("reset overflow", overflow, 1'b0);
    rst_n = 1'b1;
    repeat (140) @(negedge clk);
    run_line(8'h10, 1'b0, 256, "empty10");
    run_line(8'h11, 1'b0, 256, "empty11");

    // single hit: entry 3, row 5
    set_obj(3, 8'h24, 8'h40, 8'h85, 8'h45);
    run_line(8'h44, 1'b0, 256, "hit scan");
    check("hit overflow", ovf_act, 1'b0);
    check("hit scan done", busy_act, 1'b0);
    clear_ram();
    exp_tbl[9] = {1'b1, 3'b101, 2'b00, 1'b1, 7'h05, 4'h5};
    run_line(8'h45, 1'b0, 256, "hit emit");
    clear_exp();

    // vflip: row 5 becomes 10
    set_obj(3, 8'h24, 8'h40, 8'h85, 8'hC5);
    run_line(8'h44, 1'b0, 256, "vflip scan");
    clear_ram();
    exp_tbl[9] = {1'b1, 3'b101, 2'b00, 1'b1, 7'h05, 4'hA};
    run_line(8'h45, 1'b0, 256, "vflip emit");
    clear_exp();

    // row bounds and disabled entry: only the row-15 object lands
    set_obj(3, 8'h24, 8'h30, 8'h85, 8'h45);
    set_obj(4, 8'h31, 8'h36, 8'h12, 8'h02);
    set_obj(6, 8'h50, 8'h35, 8'h13, 8'h02);
    set_obj(7, 8'h60, 8'h45, 8'h14, 8'h07);
    run_line(8'h44, 1'b0, 256, "bounds scan");
    clear_ram();
    exp_tbl[12] = {1'b0, 3'b010, 2'b01, 1'b0, 7'h12, 4'hF};
    run_line(8'h45, 1'b0, 256, "bounds emit");
    clear_exp();

    // target line wraps from V=FF to 00; last slot with vflip
    set_obj(0, 8'hFC, 8'hF8, 8'hFF, 8'h83);
    run_line(8'hFF, 1'b0, 256, "wrap scan");
    clear_ram();
    exp_tbl[63] = {1'b1, 3'b011, 2'b00, 1'b0, 7'h7F, 4'h7};
    run_line(8'h00, 1'b0, 256, "wrap emit");
    clear_exp();

    // slot collision: lower index wins, no overflow
    set_obj(1, 8'h14, 8'h60, 8'h21, 8'h02);
    set_obj(9, 8'h17, 8'h60, 8'h22, 8'h43);
    run_line(8'h62, 1'b0, 256, "collide scan");
    check("collide overflow", ovf_act, 1'b0);
    clear_ram();
    exp_tbl[5] = {1'b0, 3'b010, 2'b00, 1'b0, 7'h21, 4'h3};
    run_line(8'h63, 1'b0, 256, "collide emit");
    clear_exp();

    // capacity: 18 hits in slots 0..17, only the first 16 kept
    for (int i = 0; i < 18; i++) set_obj(20 + i, 8'(i*4 + 1), 8'h51, 8'(i), 8'h01);
    run_line(8'h50, 1'b0, 256, "cap scan");
    check("cap overflow set", ovf_act, 1'b1);
    check("cap scan done", busy_act, 1'b0);
    clear_ram();
    for (int i = 0; i < 16; i++) exp_tbl[i] = {1'b0, 3'b001, 2'b01, 1'b0, 7'(i), 4'h0};
    run_line(8'h51, 1'b0, 256, "cap emit");
    check("cap overflow held", ovf_blank, 1'b1);
    check("cap overflow cleared", ovf_act, 1'b0);
    clear_exp();

    // abort: short line ends mid-scan; entry 2 made it, entry 60 did not
    set_obj(2, 8'h80, 8'h71, 8'h0A, 8'h04);
    set_obj(60, 8'h90, 8'h71, 8'h0B, 8'h04);
    run_line(8'h70, 1'b0, 100, "abort scan");
    check("abort busy at HB", busy_act, 1'b1);
    clear_ram();
    exp_tbl[32] = {1'b0, 3'b100, 2'b00, 1'b0, 7'h0A, 4'h0};
    run_line(8'h71, 1'b0, 256, "abort emit");
    check("abort overflow", ovf_blank, 1'b1);
    check("abort overflow cleared", ovf_act, 1'b0);
    clear_exp();
    run_line(8'h72, 1'b0, 256, "clean a");
    run_line(8'h73, 1'b0, 256, "clean b");

    // VB: last visible scan survives to line 0; entry 5 would only hit a VB scan
    set_obj(4, 8'h40, 8'hED, 8'h33, 8'h05);
    set_obj(5, 8'h44, 8'hF1, 8'h34, 8'h05);
    run_line(8'hEF, 1'b0, 256, "vb last");
    run_line(8'hF0, 1'b1, 256, "vb0");
    run_line(8'hF1, 1'b1, 256, "vb1");
    check("vb no scan", busy_act, 1'b0);
    run_line(8'hF2, 1'b1, 256, "vb2");
    clear_ram();
    exp_tbl[16] = {1'b0, 3'b101, 2'b00, 1'b0, 7'h33, 4'h3};
    run_line(8'h00, 1'b0, 256, "vb line0");
    clear_exp();
    run_line(8'h01, 1'b0, 256, "vb line1");

    // reset mid-line with live data in the tables
    set_obj(3, 8'h24, 8'h40, 8'h85, 8'h45);
    set_obj(10, 8'hA0, 8'h40, 8'h11, 8'h01);
    run_line(8'h44, 1'b0, 256, "pre-rst scan");
    clear_ram();
    exp_tbl[9] = {1'b1, 3'b101, 2'b00, 1'b1, 7'h05, 4'h5};
    run_line(8'h45, 1'b0, 40, "pre-rst emit");
    check("pre-reset DJ", DJ, {1'b1, 3'b101, 2'b00, 1'b1, 7'h05, 4'h5});
    rst_n = 1'b0;
    #1;
    check("mid-line reset DJ", DJ, EMPTY);
    check("mid-line reset busy", scan_busy, 1'b0);
    clear_exp();
    @(negedge clk);
    HB = 1'b1; pxl_cen = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (140) @(negedge clk);
    run_line(8'h10, 1'b0, 256, "post-rst a");
    run_line(8'h11, 1'b0, 256, "post-rst b");
    run_line(8'hF0, 1'b1, 256, "post-rst vb");
    run_line(8'h00, 1'b0, 256, "post-rst c");
    run_line(8'h01, 1'b0, 256, "post-rst d");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
